// File: rtl/fir_out_fifo.sv
// -----------------------------------------------------------------------------
// fir_out_fifo
//
// Output buffer behind the FIR core's AXI-Stream master. Filtered samples and
// their tlast marker go into a small first-word-fall-through FIFO and are
// re-presented on an AXI-Stream master port, so consumer back-pressure never
// stalls the FIR in the middle of its tap loop. The block also counts
// completed input frames, pulses frame_done when a tlast beat leaves, and can
// optionally check each frame's length against frame_len.
//
// Optional feature macro: FIR_OUT_LEN_CHECK_EN
//   defined   : sample counter and frame-length checker are built; len_err is a
//               sticky flag cleared by err_clr.
//   undefined : no counter or checker; len_err is tied to 0, err_clr and
//               frame_len are ignored.
//
// Ports
//   axis_clk   in   sole clock, rising edge
//   axis_rst   in   synchronous, active-high reset
//   ss_tvalid  in   input sample valid
//   ss_tdata   in   input sample
//   ss_tlast   in   last sample of a frame
//   ss_tready  out  input ready (FIFO not full)
//   sm_tvalid  out  output valid (FIFO not empty)
//   sm_tdata   out  head-of-FIFO sample
//   sm_tlast   out  tlast stored with the head entry
//   sm_tready  in   consumer ready
//   frame_len  in   expected samples per frame (>= 1)
//   err_clr    in   one-cycle pulse clearing len_err
//   level      out  current FIFO occupancy
//   frame_cnt  out  frames whose tlast beat was accepted at the input
//   frame_done out  one-cycle pulse after a tlast beat is accepted at the output
//   len_err    out  sticky frame-length error
// -----------------------------------------------------------------------------
module fir_out_fifo #(
   parameter int pDATA_WIDTH = 32,
   parameter int pDEPTH      = 8,
   parameter int pLEN_WIDTH  = 10
) (
   input  logic                       axis_clk,
   input  logic                       axis_rst,
   input  logic                       ss_tvalid,
   input  logic [pDATA_WIDTH-1:0]     ss_tdata,
   input  logic                       ss_tlast,
   output logic                       ss_tready,
   output logic                       sm_tvalid,
   output logic [pDATA_WIDTH-1:0]     sm_tdata,
   output logic                       sm_tlast,
   input  logic                       sm_tready,
   input  logic [pLEN_WIDTH-1:0]      frame_len,
   input  logic                       err_clr,
   output logic [$clog2(pDEPTH):0]    level,
   output logic [15:0]                frame_cnt,
   output logic                       frame_done,
   output logic                       len_err
);

   localparam int AW = $clog2(pDEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } frame_state_t;

   // Each entry holds {tlast, data}.
   logic [pDATA_WIDTH:0] mem [pDEPTH];

   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic                 empty;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic [pDATA_WIDTH:0] head;

   frame_state_t         state_q;
   frame_state_t         state_d;

   // The extra pointer MSB separates "same index, one lap apart" (full) from
   // "same index, same lap" (empty).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // No pass-through when full: a same-cycle pop does not open the input.
   assign ss_tready = !full;
   assign sm_tvalid = !empty;

   assign push = ss_tvalid && ss_tready;
   assign pop  = sm_tvalid && sm_tready;

   assign head     = mem[rd_ptr[AW-1:0]];
   assign sm_tdata = head[pDATA_WIDTH-1:0];
   // Stale storage is never visible as a tlast while the FIFO is empty.
   assign sm_tlast = !empty && head[pDATA_WIDTH];

   assign level = wr_ptr - rd_ptr;

   // NOTE: storage is deliberately left out of reset; the pointers alone
   // decide what is valid, and a reset-free array maps onto plain RAM/regs.
   always_ff @(posedge axis_clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {ss_tlast, ss_tdata};
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && ss_tlast) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         frame_done <= pop && head[pDATA_WIDTH];
      end
   end

   // Frame tracker: state register.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame tracker: next state, advanced only on accepted input beats. A
   // tlast beat seen in IDLE is a one-sample frame and leaves the FSM in IDLE.
   // The tracker drives no port, so there is no separate output decoder.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned
      // (which would otherwise infer a latch).
      state_d = state_q;
      if (push) begin
         unique case (state_q)
            IDLE:    if (!ss_tlast) state_d = ACTIVE;
            ACTIVE:  if (ss_tlast)  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef FIR_OUT_LEN_CHECK_EN
   localparam logic [pLEN_WIDTH-1:0] LEN_ONE = pLEN_WIDTH'(1);

   logic [pLEN_WIDTH-1:0] samp_cnt;
   logic [pLEN_WIDTH-1:0] last_idx;
   logic                  at_last;
   logic                  err_evt;
   logic                  len_err_q;

   // samp_cnt is the zero-based index of the next beat within the frame.
   assign last_idx = frame_len - LEN_ONE;
   assign at_last  = (samp_cnt == last_idx);

   // Error: tlast arrives early/late, or the last slot passes without tlast.
   assign err_evt = push && (ss_tlast ? !at_last : at_last);

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         samp_cnt  <= '0;
         len_err_q <= 1'b0;
      end else begin
         if (push) begin
            // An overrun frame restarts the count as if a new frame began.
            if (ss_tlast || at_last) begin
               samp_cnt <= '0;
            end else begin
               samp_cnt <= samp_cnt + LEN_ONE;
            end
         end
         // A new error beats a simultaneous clear.
         if (err_evt) begin
            len_err_q <= 1'b1;
         end else if (err_clr) begin
            len_err_q <= 1'b0;
         end
      end
   end

   assign len_err = len_err_q;
`else
   logic unused_len_cfg;

   assign unused_len_cfg = ^{err_clr, frame_len};
   assign len_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
module tb_fir_out_fifo;

   localparam int DW = 32;
   localparam int DEPTH = 8;
   localparam int LW = 10;

`ifdef FIR_OUT_LEN_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic                      axis_clk = 1'b0;
   logic                      axis_rst = 1'b1;
   logic                      ss_tvalid = 1'b0;
   logic [DW-1:0]             ss_tdata = '0;
   logic                      ss_tlast = 1'b0;
   logic                      ss_tready;
   logic                      sm_tvalid;
   logic [DW-1:0]             sm_tdata;
   logic                      sm_tlast;
   logic                      sm_tready = 1'b0;
   logic [LW-1:0]             frame_len = 10'd600;
   logic                      err_clr = 1'b0;
   logic [$clog2(DEPTH):0]    level;
   logic [15:0]               frame_cnt;
   logic                      frame_done;
   logic                      len_err;

   int n_checks = 0;
   int n_fail = 0;

   // Output monitor state (written only by the monitor process).
   logic [DW-1:0] popped[$];
   int            cyc = 0;
   int            done_cnt = 0;
   int            done_cyc = -1;
   int            tlast_pop_cyc = -1;

   fir_out_fifo #(
      .pDATA_WIDTH (DW),
      .pDEPTH      (DEPTH),
      .pLEN_WIDTH  (LW)
   ) dut (
      .axis_clk   (axis_clk),
      .axis_rst   (axis_rst),
      .ss_tvalid  (ss_tvalid),
      .ss_tdata   (ss_tdata),
      .ss_tlast   (ss_tlast),
      .ss_tready  (ss_tready),
      .sm_tvalid  (sm_tvalid),
      .sm_tdata   (sm_tdata),
      .sm_tlast   (sm_tlast),
      .sm_tready  (sm_tready),
      .frame_len  (frame_len),
      .err_clr    (err_clr),
      .level      (level),
      .frame_cnt  (frame_cnt),
      .frame_done (frame_done),
      .len_err    (len_err)
   );

   always #5 axis_clk = ~axis_clk;

   always @(posedge axis_clk) begin
      if (!axis_rst) begin
         if (sm_tvalid && sm_tready) begin
            popped.push_back(sm_tdata);
            if (sm_tlast) tlast_pop_cyc = cyc;
         end
         if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
         end
      end
      cyc = cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic do_reset();
      axis_rst  = 1'b1;
      ss_tvalid = 1'b0;
      ss_tlast  = 1'b0;
      sm_tready = 1'b0;
      err_clr   = 1'b0;
      tick();
      tick();
      axis_rst = 1'b0;
   endtask

   // Presents one beat and returns right after the edge that accepts it.
   task automatic push(input logic [DW-1:0] d, input logic l);
      int guard = 0;
      ss_tdata  = d;
      ss_tlast  = l;
      ss_tvalid = 1'b1;
      while (!ss_tready && guard < 50) begin
         tick();
         guard++;
      end
      if (!ss_tready) check("push_ready_timeout", ss_tready, 1'b1);
      tick();
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      ss_tvalid = 1'b0;
      ss_tlast  = 1'b0;
      sm_tready = 1'b1;
      while (sm_tvalid && guard < 64) begin
         tick();
         guard++;
      end
      check(tag, sm_tvalid, 1'b0);
      tick();
      tick();
   endtask

   initial begin
      int base;
      int dbase;

      // ---------------- reset state ----------------
      do_reset();
      check("rst_ss_tready", ss_tready, 1'b1);
      check("rst_sm_tvalid", sm_tvalid, 1'b0);
      check("rst_sm_tlast", sm_tlast, 1'b0);
      check("rst_level", level, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_len_err", len_err, 1'b0);

      // ---------------- single beat ----------------
      sm_tready = 1'b1;
      push(32'h0000_1234, 1'b0);
      ss_tvalid = 1'b0;
      check("single_valid", sm_tvalid, 1'b1);
      check("single_data", sm_tdata, 32'h1234);
      check("single_level1", level, 1);
      check("single_ready", ss_tready, 1'b1);
      tick();
      check("single_level0", level, 0);
      check("single_empty", sm_tvalid, 1'b0);
      check("single_ready2", ss_tready, 1'b1);

      // ---------------- fill and back-pressure ----------------
      do_reset();
      base = popped.size();
      for (int i = 0; i < 8; i++) begin
         push(i, 1'b0);
         if (i < 7) check("fill_ready_open", ss_tready, 1'b1);
      end
      check("fill_ready_low", ss_tready, 1'b0);
      check("fill_level8", level, 8);
      check("fill_head", sm_tdata, 0);
      ss_tdata  = 32'd8;
      ss_tlast  = 1'b0;
      ss_tvalid = 1'b1;
      tick();
      tick();
      check("fill_blocked_level", level, 8);
      check("fill_head_stable", sm_tdata, 0);
      sm_tready = 1'b1;
      tick();
      check("fill_first_pop_level", level, 7);
      check("fill_ready_reopen", ss_tready, 1'b1);
      tick();
      check("fill_beat8_level", level, 7);
      drain("fill_drain");
      check("fill_count", popped.size() - base, 9);
      for (int i = 0; i < 9; i++) begin
         if (base + i < popped.size()) check($sformatf("fill_order%0d", i), popped[base + i], i);
      end

      // ---------------- simultaneous push and pop ----------------
      do_reset();
      base = popped.size();
      for (int i = 0; i < 3; i++) push(100 + i, 1'b0);
      check("sim_level3", level, 3);
      sm_tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push(103 + i, 1'b0);
         check($sformatf("sim_level_c%0d", i), level, 3);
      end
      drain("sim_drain");
      check("sim_count", popped.size() - base, 23);
      for (int i = 0; i < 23; i++) begin
         if (base + i < popped.size()) check($sformatf("sim_order%0d", i), popped[base + i], 100 + i);
      end

      // ---------------- 600-sample frame ----------------
      do_reset();
      base  = popped.size();
      dbase = done_cnt;
      frame_len = 10'd600;
      sm_tready = 1'b1;
      for (int i = 1; i <= 600; i++) push(i, i == 600);
      drain("f600_drain");
      check("f600_count", popped.size() - base, 600);
      check("f600_frame_cnt", frame_cnt, 1);
      check("f600_done_pulses", done_cnt - dbase, 1);
      check("f600_done_latency", done_cyc, tlast_pop_cyc + 1);
      check("f600_len_err", len_err, 1'b0);
      check("f600_done_low", frame_done, 1'b0);

      // ---------------- length errors ----------------
      do_reset();
      frame_len = 10'd600;
      sm_tready = 1'b1;
      for (int i = 1; i <= 599; i++) push(i, i == 599);
      ss_tvalid = 1'b0;
      check("short_len_err", len_err, EXP_ERR);
      check("short_frame_cnt", frame_cnt, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr_len_err", len_err, 1'b0);
      for (int i = 1; i <= 599; i++) push(i, 1'b0);
      check("long_599_ok", len_err, 1'b0);
      push(600, 1'b0);
      check("long_600_err", len_err, EXP_ERR);
      push(601, 1'b0);
      ss_tvalid = 1'b0;
      check("long_601_sticky", len_err, EXP_ERR);
      drain("len_drain");

      // One-sample frame, then error coinciding with err_clr.
      do_reset();
      sm_tready = 1'b1;
      frame_len = 10'd1;
      push(32'hA, 1'b1);
      ss_tvalid = 1'b0;
      check("one_sample_ok", len_err, 1'b0);
      check("one_sample_cnt", frame_cnt, 1);
      frame_len = 10'd2;
      push(32'hB, 1'b0);
      check("pre_overrun_ok", len_err, 1'b0);
      err_clr = 1'b1;
      push(32'hC, 1'b0);
      err_clr = 1'b0;
      ss_tvalid = 1'b0;
      check("err_beats_clr", len_err, EXP_ERR);
      drain("coinc_drain");

      // ---------------- reset mid-frame ----------------
      do_reset();
      for (int i = 0; i < 5; i++) push(200 + i, 1'b0);
      ss_tvalid = 1'b0;
      check("mid_level5", level, 5);
      axis_rst = 1'b1;
      tick();
      check("mid_rst_level", level, 0);
      check("mid_rst_valid", sm_tvalid, 1'b0);
      check("mid_rst_ready", ss_tready, 1'b1);
      check("mid_rst_frame_cnt", frame_cnt, 0);
      axis_rst = 1'b0;
      check("mid_post_ready", ss_tready, 1'b1);
      tick();
      check("mid_post_level", level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
